// File: rtl/obi_addr_demux.sv
// obi_addr_demux -- one OBI manager port routed to NumRules subordinate ports.
//
// The routing table is a runtime input of {last, base} pairs. Rule k matches
// base_k <= addr < last_k (unsigned, last exclusive), and the lowest matching
// index wins. Requests that match no rule are answered by an internal error
// responder (index NumRules). Responses come back in order because a request
// to a different target is held off until every outstanding transaction to
// the current target has been answered.
//
// Handshake: a request is accepted in the cycle where req_i && gnt_o. gnt_o is
// a combinational pass-through of the selected subordinate's grant. The
// manager keeps req_i and its payload stable until it sees gnt_o. Each
// rvalid_o pulse retires exactly one accepted request.
//
// Build option: DEMUX_DEFAULT_PORT_EN sends unmapped addresses to subordinate
// DefaultIdx as if they matched that rule. This removes the error responder,
// and decode_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rules_i               rule k = {last, base} at [k*2*AddrWidth +: 2*AddrWidth]
//   req_i/gnt_o           manager request / grant
//   addr_i/we_i/be_i/wdata_i  manager request payload
//   rvalid_o/rdata_o/err_o    manager response
//   sbr_req_o/sbr_gnt_i   per-subordinate request / grant
//   sbr_addr_o/sbr_we_o/sbr_be_o/sbr_wdata_o  payload broadcast to all subordinates
//   sbr_rvalid_i/sbr_rdata_i/sbr_err_i        per-subordinate response
//   decode_err_o          sticky: an unmapped access was accepted since reset
module obi_addr_demux #(
  parameter int unsigned NumRules   = 6,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MaxTrans   = 4,
  parameter int unsigned DefaultIdx = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumRules*2*AddrWidth-1:0] rules_i,
  input  logic                            req_i,
  output logic                            gnt_o,
  input  logic [AddrWidth-1:0]            addr_i,
  input  logic                            we_i,
  input  logic [DataWidth/8-1:0]          be_i,
  input  logic [DataWidth-1:0]            wdata_i,
  output logic                            rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic                            err_o,
  output logic [NumRules-1:0]             sbr_req_o,
  input  logic [NumRules-1:0]             sbr_gnt_i,
  output logic [AddrWidth-1:0]            sbr_addr_o,
  output logic                            sbr_we_o,
  output logic [DataWidth/8-1:0]          sbr_be_o,
  output logic [DataWidth-1:0]            sbr_wdata_o,
  input  logic [NumRules-1:0]             sbr_rvalid_i,
  input  logic [NumRules*DataWidth-1:0]   sbr_rdata_i,
  input  logic [NumRules-1:0]             sbr_err_i,
  output logic                            decode_err_o
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned TgtW = $clog2(NumRules + 1);
  localparam logic [TgtW-1:0] ErrIdx = TgtW'(NumRules);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  if (NumRules < 1 || NumRules > 16 || MaxTrans < 1 || MaxTrans > 15 ||
      DataWidth % 8 != 0 || DefaultIdx >= NumRules) begin : g_param_check
    $error("obi_addr_demux: parameter out of range");
  end

  // State
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TgtW-1:0] tgt_q, tgt_d;

  // Rule table unpacked into base/last arrays
  logic [AddrWidth-1:0] rule_base [NumRules];
  logic [AddrWidth-1:0] rule_last [NumRules];

  for (genvar k = 0; k < NumRules; k++) begin : g_rules
    assign rule_base[k] = rules_i[k*2*AddrWidth +: AddrWidth];
    assign rule_last[k] = rules_i[k*2*AddrWidth + AddrWidth +: AddrWidth];
  end

  // Address decode: lowest matching rule wins; no match selects ErrIdx.
  logic [TgtW-1:0] sel;
  logic            found;

  always_comb begin
    sel   = ErrIdx;
    found = 1'b0;
    for (int unsigned k = 0; k < NumRules; k++) begin
      if (!found && (rule_base[k] < rule_last[k]) &&
          (addr_i >= rule_base[k]) && (addr_i < rule_last[k])) begin
        sel   = TgtW'(k);
        found = 1'b1;
      end
    end
`ifdef DEMUX_DEFAULT_PORT_EN
    if (!found) begin
      sel = TgtW'(DefaultIdx);
    end
`endif
  end

  // A new request may only go out when nothing is in flight or it targets
  // the same port as the in-flight ones; this keeps responses in order.
  logic issue_ok;
  assign issue_ok = !rst_i && req_i && ((cnt_q == '0) || (sel == tgt_q)) &&
                    (cnt_q < CntMax);

  always_comb begin
    sbr_req_o = '0;
    gnt_o     = 1'b0;
    if (issue_ok) begin
`ifndef DEMUX_DEFAULT_PORT_EN
      if (sel == ErrIdx) begin
        gnt_o = 1'b1;
      end
`endif
      for (int unsigned k = 0; k < NumRules; k++) begin
        if (sel == TgtW'(k)) begin
          sbr_req_o[k] = 1'b1;
          gnt_o        = sbr_gnt_i[k];
        end
      end
    end
  end

  assign sbr_addr_o  = addr_i;
  assign sbr_we_o    = we_i;
  assign sbr_be_o    = be_i;
  assign sbr_wdata_o = wdata_i;

  logic accept;
  assign accept = req_i && gnt_o;

  // Response mux from the current target only. Responses with nothing in
  // flight are dropped so the counter cannot underflow.
  logic                 rsp_raw;
  logic                 rsp_err;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_fire;

`ifndef DEMUX_DEFAULT_PORT_EN
  logic err_pend_q, err_pend_d;
  logic decode_err_q, decode_err_d;
`endif

  always_comb begin
    rsp_raw  = 1'b0;
    rsp_err  = 1'b0;
    rsp_data = '0;
`ifndef DEMUX_DEFAULT_PORT_EN
    // Error responder answers reads and writes alike with zero data.
    if (tgt_q == ErrIdx) begin
      rsp_raw = err_pend_q;
      rsp_err = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NumRules; k++) begin
      if (tgt_q == TgtW'(k)) begin
        rsp_raw  = sbr_rvalid_i[k];
        rsp_err  = sbr_err_i[k];
        rsp_data = sbr_rdata_i[k*DataWidth +: DataWidth];
      end
    end
  end

  assign rsp_fire = !rst_i && rsp_raw && (cnt_q != '0);
  assign rvalid_o = rsp_fire;
  assign rdata_o  = rsp_fire ? rsp_data : '0;
  assign err_o    = rsp_fire && rsp_err;

  // Next-state logic
  always_comb begin
    tgt_d = accept ? sel : tgt_q;
    cnt_d = cnt_q;
    case ({accept, rsp_fire})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifndef DEMUX_DEFAULT_PORT_EN
  // One accepted error request produces exactly one response next cycle.
  always_comb begin
    err_pend_d   = accept && (sel == ErrIdx);
    decode_err_d = decode_err_q || (accept && (sel == ErrIdx));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pend_q   <= 1'b0;
      decode_err_q <= 1'b0;
    end else begin
      err_pend_q   <= err_pend_d;
      decode_err_q <= decode_err_d;
    end
  end

  assign decode_err_o = decode_err_q;
`else
  assign decode_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

endmodule

// File: doc/obi_addr_demux.md
Name: obi_addr_demux

Overview:
- Parametrised successor to the fixed six-entry system address map.
- Takes one OBI manager port and routes each request to one of NumRules subordinate ports. The routing table is a runtime input of base/last rule pairs, not a compile-time map.
- Tracks outstanding transactions so responses return in order.
- Requests that match no rule go to an internal error responder.
- Sits between the core data port and the imem/dmem/clic/uart/ext subordinates.

Parameters:
- NumRules, 6, number of subordinate ports and address rules (1..16).
- AddrWidth, 32, address width in bits.
- DataWidth, 32, data width in bits (multiple of 8).
- MaxTrans, 4, maximum outstanding transactions (1..15).
- DefaultIdx, 0, subordinate index used for unmapped addresses when DEMUX_DEFAULT_PORT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rules_i  in  NumRules*2*AddrWidth  rule k = {last, base} at bits [k*2*AddrWidth +: 2*AddrWidth]
- req_i  in  1  manager request
- gnt_o  out  1  manager grant
- addr_i  in  AddrWidth  request address
- we_i  in  1  write enable
- be_i  in  DataWidth/8  byte enables
- wdata_i  in  DataWidth  write data
- rvalid_o  out  1  response valid
- rdata_o  out  DataWidth  response data
- err_o  out  1  response error
- sbr_req_o  out  NumRules  per-subordinate request
- sbr_gnt_i  in  NumRules  per-subordinate grant
- sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o  out  as manager  broadcast to all subordinates
- sbr_rvalid_i  in  NumRules  per-subordinate response valid
- sbr_rdata_i  in  NumRules*DataWidth  per-subordinate read data
- sbr_err_i  in  NumRules  per-subordinate error
- decode_err_o  out  1  sticky flag: an unmapped access occurred

Behaviour:
- Decode is combinational on addr_i.
  - Rule k matches when base_k <= addr_i < last_k (last is exclusive, unsigned compare).
  - The lowest matching index wins.
  - A rule with base >= last never matches.
  - No match selects the error target (index NumRules).
- State registers:
  - cnt_q, outstanding count, width clog2(MaxTrans+1).
  - tgt_q, target of the outstanding transactions, width clog2(NumRules+1).
  - err_pend_q.
  - decode_err_q.
- Issue condition: req_i && (cnt_q == 0 || sel == tgt_q) && cnt_q < MaxTrans.
  - If false: all sbr_req_o = 0 and gnt_o = 0. The manager holds its request.
  - This blocks a target switch while transactions are in flight, which guarantees in-order responses.
- When the issue condition holds:
  - sbr_req_o[sel] = 1 and gnt_o = sbr_gnt_i[sel] in the same cycle (combinational pass-through).
  - Error target: gnt_o = 1 immediately.
- On an accepted request (req_i && gnt_o):
  - tgt_q <= sel.
  - cnt_q increments.
- Responses:
  - rvalid_o = sbr_rvalid_i[tgt_q], with rdata and err muxed from the same index.
  - A response from any other subordinate is ignored.
  - Each response decrements cnt_q.
  - Simultaneous accept and response: cnt_q unchanged.
- Error responder:
  - An accepted error-target request sets err_pend_q.
  - Next cycle: rvalid_o = 1, err_o = 1, rdata_o = 0 for reads and writes; err_pend_q clears.
  - decode_err_q sets and stays set until reset.
- cnt_q never wraps:
  - Increments are blocked at MaxTrans.
  - A response while cnt_q == 0 is ignored (no underflow). This is a protocol violation, not flagged.
- Reset (any cycle, including mid-transaction):
  - cnt_q = 0, tgt_q = 0, err_pend_q = 0, decode_err_q = 0.
  - Outputs gnt_o = 0, rvalid_o = 0, rdata_o = 0, err_o = 0, sbr_req_o = 0, decode_err_o = 0.
  - Responses arriving in the cycle after reset deasserts are dropped (cnt_q == 0).
- rules_i may change only while cnt_q == 0. Otherwise behaviour is undefined.

Optional Feature:
- DEMUX_DEFAULT_PORT_EN defined:
  - Unmapped addresses route to subordinate DefaultIdx and are treated exactly like a match on that rule.
  - The internal error responder and decode_err_o logic are removed; decode_err_o is tied to 0.
- Not defined: the error responder behaviour above applies.

Test Plan:
- Default six-rule map, read at 0x5004 with dmem granting immediately and rvalid one cycle later with 0xDEADBEEF:
  - sbr_req_o = 6'b000100.
  - gnt_o is high in the same cycle.
  - rvalid_o = 1 and rdata_o = 0xDEADBEEF one cycle after.
- Boundary decode:
  - 0x4FFC selects imem; 0x5000 selects dmem.
  - 0xA100 matches no rule: error response next cycle with err_o = 1, and decode_err_o stays 1.
- Overlapping rules 0 and 1 both cover 0x2000 -> port 0 selected.
- MaxTrans = 4, imem grants but withholds rvalid:
  - Exactly 4 grants, then gnt_o = 0.
  - One rvalid -> the fifth grant is accepted.
- Target switch: two outstanding to imem, new request to uart:
  - uart sbr_req_o stays 0 until both imem responses return.
  - Next cycle, uart is requested.
- Reset asserted with cnt_q = 3:
  - All outputs 0 the next cycle.
  - A stale imem rvalid after reset gives rvalid_o = 0.
  - With DEMUX_DEFAULT_PORT_EN, address 0xA100 goes to port DefaultIdx.
